// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
// Contents: digit counts, output width, blank/max digit codes, state enum.
package bcd_pkg;

   localparam int NUM_DIGITS = 5;
   localparam int ACC_DIGITS = 6;
   localparam int OUT_W      = 21;

   localparam logic [3:0] DIGIT_BLANK = 4'hD;
   localparam logic [3:0] DIGIT_MAX   = 4'h9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Ports: digit (4-bit BCD digit), adj (corrected digit).
module bcd_add3 (
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential signed binary to sign/magnitude BCD converter (double dabble).
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data handshake in,
//   out_valid pulse, out_data {sign, 5 BCD digits}, ovf saturation flag.
// Build option: define BCD_LZB_EN for leading-zero blanking of the result.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int IN_W = 18
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   output logic            out_valid,
   output logic [20:0]     out_data,
   output logic            ovf
);

   localparam int CNT_W = $clog2(IN_W);
   localparam int ACC_W = 4 * ACC_DIGITS;
   localparam int DIG_W = 4 * NUM_DIGITS;

`ifdef BCD_LZB_EN
   localparam logic [OUT_W-1:0] RST_DATA =
      {1'b0, {(NUM_DIGITS-1){DIGIT_BLANK}}, 4'h0};
`else
   localparam logic [OUT_W-1:0] RST_DATA = '0;
`endif

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [IN_W-1:0]   mag_q;
   logic [ACC_W-1:0]  bcd_q;
   logic [ACC_W-1:0]  bcd_adj;
   logic              sign_q;
   logic              accept;
   logic              last_bit;
   logic              sat;
   logic [DIG_W-1:0]  digits;
   logic [IN_W-1:0]   mag_in;
   logic              unused_msb;

   assign in_ready = (state_q == IDLE);
   assign accept   = in_ready & in_valid;
   assign last_bit = (cnt_q == '0);

   // Negation of the most negative value wraps to 2^(IN_W-1), which is
   // exactly the right magnitude when read as unsigned.
   assign mag_in = in_data[IN_W-1] ? -in_data : in_data;

   for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit (bcd_q[4*g +: 4]),
         .adj   (bcd_adj[4*g +: 4])
      );
   end

   // The top accumulator digit never reaches 5 for IN_W <= 20, so its
   // corrected MSB is shifted out without loss.
   assign unused_msb = bcd_adj[ACC_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         mag_q  <= '0;
         bcd_q  <= '0;
         sign_q <= 1'b0;
      end else if (accept) begin
         cnt_q  <= CNT_W'(IN_W - 1);
         mag_q  <= mag_in;
         bcd_q  <= '0;
         sign_q <= in_data[IN_W-1];
      end else if (state_q == SHIFT) begin
         cnt_q  <= cnt_q - CNT_W'(1);
         mag_q  <= {mag_q[IN_W-2:0], 1'b0};
         bcd_q  <= {bcd_adj[ACC_W-2:0], mag_q[IN_W-1]};
      end
   end

`ifdef BCD_LZB_EN
   logic lead;
`endif

   always_comb begin
      sat    = |bcd_q[ACC_W-1:DIG_W];
      digits = sat ? {NUM_DIGITS{DIGIT_MAX}} : bcd_q[DIG_W-1:0];
`ifdef BCD_LZB_EN
      // Blank zeros above the first non-zero digit; units always shown.
      lead = !sat;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         if (lead && digits[4*i +: 4] == 4'h0) begin
            digits[4*i +: 4] = DIGIT_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= RST_DATA;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_q == FIN);
         if (state_q == FIN) begin
            out_data <= {sign_q, digits};
            ovf      <= sat;
         end
      end
   end

endmodule
